// File: rtl/noc_stats_pkg.sv
// Shared types and helpers for the per-node receive statistics logic.
// Counter readout selectors, readout FSM states and a width-generic saturating add.
package noc_stats_pkg;

    typedef enum logic [1:0] {
        SEL_RX,
        SEL_LOST,
        SEL_OOO,
        SEL_MISROUTE
    } stat_sel_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    // Saturating add for counters up to 32 bits wide; width selects the ceiling.
    function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                            input logic [31:0] inc,
                                            input int unsigned width);
        logic [32:0] w_sum;
        logic [32:0] w_max;
        w_sum = {1'b0, cnt} + {1'b0, inc};
        w_max = (33'd1 << width) - 33'd1;
        return (w_sum > w_max) ? w_max[31:0] : w_sum[31:0];
    endfunction

endpackage

// File: rtl/seq_tracker.sv
// Per-source packet-id sequence state (seen / expected id) and classification of
// the presented id as in-order, forward gap (lost packets) or late/duplicate.
module seq_tracker
    import noc_stats_pkg::*;
#(
    parameter int NODE_COUNT      = 9,
    parameter int PACKET_ID_WIDTH = 5,
    localparam int SRC_W          = $clog2(NODE_COUNT)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clear,
    input  logic                       i_update,
    input  logic [SRC_W-1:0]           i_src,
    input  logic [PACKET_ID_WIDTH-1:0] i_id,
    output logic                       o_in_order,
    output logic [PACKET_ID_WIDTH-1:0] o_lost_gap,
    output logic                       o_ooo
);

    localparam int W = PACKET_ID_WIDTH;

    logic         r_seen     [NODE_COUNT];
    logic [W-1:0] r_expected [NODE_COUNT];

    logic         w_src_ok;
    logic         w_seen;
    logic [W-1:0] w_exp;
    logic [W-1:0] w_gap;

    always_comb begin
        w_src_ok   = {1'b0, i_src} < (SRC_W+1)'(NODE_COUNT);
        w_seen     = w_src_ok ? r_seen[i_src] : 1'b0;
        w_exp      = w_src_ok ? r_expected[i_src] : '0;
        // Modular distance; the top half of the id space means "behind us".
        w_gap      = i_id - w_exp;
        o_in_order = !w_seen || (i_id == w_exp);
        o_ooo      = !o_in_order && w_gap[W-1];
        o_lost_gap = (!o_in_order && !w_gap[W-1]) ? w_gap : '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                r_seen[i]     <= 1'b0;
                r_expected[i] <= '0;
            end
        end else if (i_update && !o_ooo) begin
            r_seen[i_src]     <= 1'b1;
            r_expected[i_src] <= i_id + W'(1);
        end
    end

endmodule

// File: rtl/rx_traffic_monitor.sv
// Receive-side statistics stage: per-source rx/lost/out-of-order counters, a global
// misroute counter, a sticky error flag and a two-state req/ack counter readout.
module rx_traffic_monitor
    import noc_stats_pkg::*;
#(
    parameter int NODE_ID         = 0,
    parameter int NODE_COUNT      = 9,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int CNT_WIDTH       = 16,
    localparam int SRC_W          = $clog2(NODE_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [31:0]                packet_in,
    input  logic [SRC_W-1:0]           node_start_in,
    input  logic [SRC_W-1:0]           node_dest_in,
    input  logic [PACKET_ID_WIDTH-1:0] packet_id_in,
    input  logic                       clear,
    input  logic                       rd_req,
    input  logic [SRC_W-1:0]           rd_src,
    input  logic [1:0]                 rd_sel,
    output logic                       rd_ack,
    output logic [CNT_WIDTH-1:0]       rd_data,
    output logic                       error_flag,
    output rd_state_t                  o_dbg_rd_state
);

    logic [CNT_WIDTH-1:0] r_rx_cnt   [NODE_COUNT];
    logic [CNT_WIDTH-1:0] r_lost_cnt [NODE_COUNT];
    logic [CNT_WIDTH-1:0] r_ooo_cnt  [NODE_COUNT];
    logic [CNT_WIDTH-1:0] r_misroute_cnt;
    logic                 r_error_flag;
    rd_state_t            r_rd_state;
    logic                 r_rd_ack;
    logic [CNT_WIDTH-1:0] r_rd_data;

    logic                       w_src_ok;
    logic                       w_misroute;
    logic                       w_pkt;
    logic                       w_update;
    logic                       w_in_order;
    logic [PACKET_ID_WIDTH-1:0] w_lost_gap;
    logic                       w_ooo;
    logic                       w_rd_src_ok;
    logic [CNT_WIDTH-1:0]       w_rd_value;

    function automatic logic [CNT_WIDTH-1:0] cnt_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic [31:0] inc);
        return CNT_WIDTH'(sat_add(32'(cnt), inc, CNT_WIDTH));
    endfunction

    always_comb begin
        w_src_ok    = {1'b0, node_start_in} < (SRC_W+1)'(NODE_COUNT);
        w_misroute  = (node_dest_in != SRC_W'(NODE_ID)) || !w_src_ok;
        // clear takes priority over a packet presented in the same cycle
        w_pkt       = valid_in && !clear;
        w_update    = w_pkt && !w_misroute;
        w_rd_src_ok = {1'b0, rd_src} < (SRC_W+1)'(NODE_COUNT);
    end

    seq_tracker #(
        .NODE_COUNT      (NODE_COUNT),
        .PACKET_ID_WIDTH (PACKET_ID_WIDTH)
    ) u_seq_tracker (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clear    (clear),
        .i_update   (w_update),
        .i_src      (node_start_in),
        .i_id       (packet_id_in),
        .o_in_order (w_in_order),
        .o_lost_gap (w_lost_gap),
        .o_ooo      (w_ooo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                r_rx_cnt[i]   <= '0;
                r_lost_cnt[i] <= '0;
                r_ooo_cnt[i]  <= '0;
            end
            r_misroute_cnt <= '0;
            r_error_flag   <= 1'b0;
        end else if (w_pkt) begin
            if (w_misroute) begin
                r_misroute_cnt <= cnt_add(r_misroute_cnt, 32'd1);
                r_error_flag   <= 1'b1;
            end else begin
                r_rx_cnt[node_start_in] <= cnt_add(r_rx_cnt[node_start_in], 32'd1);
                if (w_lost_gap != '0) begin
                    r_lost_cnt[node_start_in] <= cnt_add(r_lost_cnt[node_start_in],
                                                         32'(w_lost_gap));
                end
                if (w_ooo) begin
                    r_ooo_cnt[node_start_in] <= cnt_add(r_ooo_cnt[node_start_in], 32'd1);
                end
                if (!w_in_order) begin
                    r_error_flag <= 1'b1;
                end
            end
        end
    end

    // Readout mux looks at counter state before this edge's packet update.
    always_comb begin
        w_rd_value = '0;
        case (stat_sel_t'(rd_sel))
            SEL_RX:       if (w_rd_src_ok) w_rd_value = r_rx_cnt[rd_src];
            SEL_LOST:     if (w_rd_src_ok) w_rd_value = r_lost_cnt[rd_src];
            SEL_OOO:      if (w_rd_src_ok) w_rd_value = r_ooo_cnt[rd_src];
            SEL_MISROUTE: w_rd_value = r_misroute_cnt;
            default:      w_rd_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_state <= RD_IDLE;
            r_rd_ack   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    r_rd_ack <= 1'b0;
                    if (rd_req) begin
                        r_rd_data  <= w_rd_value;
                        r_rd_ack   <= 1'b1;
                        r_rd_state <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    r_rd_ack   <= 1'b0;
                    r_rd_state <= RD_IDLE;
                end
                default: begin
                    r_rd_ack   <= 1'b0;
                    r_rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && valid_in) begin
            assert (!$isunknown(packet_in));
        end
    end

    assign rd_ack         = r_rd_ack;
    assign rd_data        = r_rd_data;
    assign error_flag     = r_error_flag;
    assign o_dbg_rd_state = r_rd_state;

endmodule

// File: tb/tb_rx_traffic_monitor.sv
// Bench for rx_traffic_monitor: a 16-bit instance plus a 4-bit-counter instance on the
// same stimulus, so counter saturation is reachable in a short run.
module tb_rx_traffic_monitor;

  localparam int NID = 4;
  localparam int NC  = 9;
  localparam int W   = 5;
  localparam int SW  = 4;
  localparam int MAX16 = 65535;
  localparam int MAX4  = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [31:0]   packet_in;
  logic [SW-1:0] node_start_in;
  logic [SW-1:0] node_dest_in;
  logic [W-1:0]  packet_id_in;
  logic          clear;
  logic          rd_req;
  logic [SW-1:0] rd_src;
  logic [1:0]    rd_sel;
  logic          rd_ack;
  logic [15:0]   rd_data;
  logic          error_flag;
  noc_stats_pkg::rd_state_t dbg_state;
  logic          sat_rd_ack;
  logic [3:0]    sat_rd_data;
  logic          sat_error_flag;
  noc_stats_pkg::rd_state_t sat_dbg_state;

  int checks = 0;
  int failures = 0;

  // reference model: true (unsaturated) event totals per source
  int t_rx[NC];
  int t_lost[NC];
  int t_ooo[NC];
  int t_mis;
  bit m_seen[NC];
  int m_exp[NC];
  bit m_err;

  typedef struct {
    int src;
    int dest;
    int id;
    int rx;
    int lost;
    int ooo;
    int mis;
    int err;
  } vec_t;

  vec_t vecs[12];

  rx_traffic_monitor #(
    .NODE_ID(NID), .NODE_COUNT(NC), .PACKET_ID_WIDTH(W), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .packet_in(packet_in),
    .node_start_in(node_start_in), .node_dest_in(node_dest_in),
    .packet_id_in(packet_id_in), .clear(clear), .rd_req(rd_req),
    .rd_src(rd_src), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data),
    .error_flag(error_flag), .o_dbg_rd_state(dbg_state)
  );

  rx_traffic_monitor #(
    .NODE_ID(NID), .NODE_COUNT(NC), .PACKET_ID_WIDTH(W), .CNT_WIDTH(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .packet_in(packet_in),
    .node_start_in(node_start_in), .node_dest_in(node_dest_in),
    .packet_id_in(packet_id_in), .clear(clear), .rd_req(rd_req),
    .rd_src(rd_src), .rd_sel(rd_sel), .rd_ack(sat_rd_ack), .rd_data(sat_rd_data),
    .error_flag(sat_error_flag), .o_dbg_rd_state(sat_dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NC; i++) begin
      t_rx[i] = 0; t_lost[i] = 0; t_ooo[i] = 0; m_seen[i] = 0; m_exp[i] = 0;
    end
    t_mis = 0;
    m_err = 0;
  endfunction

  function automatic void model_pkt(input int src, input int dest, input int id);
    int gap;
    if (dest != NID || src >= NC) begin
      t_mis++;
      m_err = 1;
    end else begin
      t_rx[src]++;
      if (!m_seen[src]) begin
        m_seen[src] = 1;
        m_exp[src] = (id + 1) % 32;
      end else if (id == m_exp[src]) begin
        m_exp[src] = (id + 1) % 32;
      end else begin
        gap = (id - m_exp[src] + 32) % 32;
        m_err = 1;
        if (gap < 16) begin
          t_lost[src] += gap;
          m_exp[src] = (id + 1) % 32;
        end else begin
          t_ooo[src]++;
        end
      end
    end
  endfunction

  function automatic int model_val(input int src, input int sel);
    if (sel == 3) return t_mis;
    if (src >= NC) return 0;
    case (sel)
      0: return t_rx[src];
      1: return t_lost[src];
      default: return t_ooo[src];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_err(input string name);
    check({name, "_err"}, 32'(error_flag), 32'(m_err));
    check({name, "_sat_err"}, 32'(sat_error_flag), 32'(m_err));
  endtask

  task automatic send_pkt(input int src, input int dest, input int id);
    valid_in = 1'b1;
    packet_in = $urandom;
    node_start_in = SW'(src);
    node_dest_in = SW'(dest);
    packet_id_in = W'(id);
    @(posedge clk); #1;
    valid_in = 1'b0;
    model_pkt(src, dest, id);
  endtask

  task automatic read_exp(input int src, input int sel, input int exp_v, input string name);
    int e16;
    int e4;
    e16 = sat(exp_v, MAX16);
    e4 = sat(exp_v, MAX4);
    rd_req = 1'b1;
    rd_src = SW'(src);
    rd_sel = 2'(sel);
    @(posedge clk); #1;
    rd_req = 1'b0;
    check({name, "_ack"}, 32'(rd_ack), 32'd1);
    check({name, "_data"}, 32'(rd_data), 32'(e16));
    check({name, "_sat_ack"}, 32'(sat_rd_ack), 32'd1);
    check({name, "_sat_data"}, 32'(sat_rd_data), 32'(e4));
    @(posedge clk); #1;
    check({name, "_ack_drop"}, 32'(rd_ack), 32'd0);
    check({name, "_hold"}, 32'(rd_data), 32'(e16));
  endtask

  task automatic read_check(input int src, input int sel, input string name);
    read_exp(src, sel, model_val(src, sel), name);
  endtask

  task automatic read_all(input string tag);
    for (int s = 0; s < NC; s++) begin
      for (int k = 0; k < 3; k++) begin
        read_check(s, k, $sformatf("%s_s%0d_k%0d", tag, s, k));
      end
    end
    read_check(0, 3, {tag, "_mis"});
  endtask

  initial begin
    int pre;
    int src;
    int dest;
    int id;
    int base;

    vecs[0]  = '{0, 4, 0,  1, 0, 0, 0, 0};
    vecs[1]  = '{0, 4, 1,  2, 0, 0, 0, 0};
    vecs[2]  = '{0, 4, 2,  3, 0, 0, 0, 0};
    vecs[3]  = '{2, 4, 5,  1, 0, 0, 0, 0};
    vecs[4]  = '{2, 4, 6,  2, 0, 0, 0, 0};
    vecs[5]  = '{2, 4, 9,  3, 2, 0, 0, 1};
    vecs[6]  = '{2, 4, 7,  4, 2, 1, 0, 1};
    vecs[7]  = '{1, 4, 30, 1, 0, 0, 0, 1};
    vecs[8]  = '{1, 4, 31, 2, 0, 0, 0, 1};
    vecs[9]  = '{1, 4, 0,  3, 0, 0, 0, 1};
    vecs[10] = '{1, 4, 1,  4, 0, 0, 0, 1};
    vecs[11] = '{1, 3, 2,  4, 0, 0, 1, 1};

    // clock/reset
    rst_n = 1'b0; valid_in = 1'b0; packet_in = '0; node_start_in = '0;
    node_dest_in = '0; packet_id_in = '0; clear = 1'b0; rd_req = 1'b0;
    rd_src = '0; rd_sel = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_ack", 32'(rd_ack), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(noc_stats_pkg::RD_IDLE));
    check_err("rst");
    read_all("rst");

    // table-driven directed vectors
    for (int i = 0; i < 12; i++) begin
      send_pkt(vecs[i].src, vecs[i].dest, vecs[i].id);
      check($sformatf("vec%0d_err", i), 32'(error_flag), 32'(vecs[i].err));
      read_exp(vecs[i].src, 0, vecs[i].rx,   $sformatf("vec%0d_rx", i));
      read_exp(vecs[i].src, 1, vecs[i].lost, $sformatf("vec%0d_lost", i));
      read_exp(vecs[i].src, 2, vecs[i].ooo,  $sformatf("vec%0d_ooo", i));
      read_exp(vecs[i].src, 3, vecs[i].mis,  $sformatf("vec%0d_mis", i));
    end

    // expected id for src 2 is still 10 after the late id 7
    send_pkt(2, 4, 10);
    read_exp(2, 1, 2, "exp10_lost");
    read_exp(2, 2, 1, "exp10_ooo");

    // readout in the same cycle as a packet from the same source
    pre = model_val(2, 0);
    valid_in = 1'b1; packet_in = $urandom; node_start_in = 4'd2; node_dest_in = 4'd4;
    packet_id_in = 5'd11; rd_req = 1'b1; rd_src = 4'd2; rd_sel = 2'd0;
    @(posedge clk); #1;
    valid_in = 1'b0; rd_req = 1'b0;
    model_pkt(2, 4, 11);
    check("same_cyc_ack", 32'(rd_ack), 32'd1);
    check("same_cyc_data", 32'(rd_data), 32'(pre));
    @(posedge clk); #1;
    check("same_cyc_ack_drop", 32'(rd_ack), 32'd0);
    read_check(2, 0, "same_cyc_after");

    // rd_req held high: ack every other cycle
    rd_req = 1'b1; rd_src = 4'd0; rd_sel = 2'd0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("held_ack%0d", i), 32'(rd_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) check($sformatf("held_data%0d", i), 32'(rd_data), 32'(t_rx[0]));
    end
    rd_req = 1'b0;
    @(posedge clk); #1;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        read_check($urandom_range(0, 10), $urandom_range(0, 3), $sformatf("rnd%0d", n));
      end else begin
        src = $urandom_range(0, 10);
        dest = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : NID;
        base = (src < NC) ? m_exp[src] : 0;
        case ($urandom_range(0, 4))
          0, 1: id = base;
          2: id = (base + $urandom_range(1, 5)) % 32;
          3: id = (base + 32 - $urandom_range(1, 5)) % 32;
          default: id = $urandom_range(0, 31);
        endcase
        send_pkt(src, dest, id);
        check_err($sformatf("rnd%0d", n));
      end
    end
    read_all("rnd_end");

    // clear during RESP keeps the in-flight response
    pre = model_val(0, 0);
    rd_req = 1'b1; rd_src = 4'd0; rd_sel = 2'd0;
    @(posedge clk); #1;
    rd_req = 1'b0;
    check("clr_resp_ack", 32'(rd_ack), 32'd1);
    check("clr_resp_data", 32'(rd_data), 32'(sat(pre, MAX16)));
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    check("clr_resp_ack_drop", 32'(rd_ack), 32'd0);
    check("clr_resp_hold", 32'(rd_data), 32'(sat(pre, MAX16)));
    check_err("clr_resp");
    read_all("clr");

    // saturation: 4-bit instance pins at 15, 16-bit instance keeps counting
    for (int i = 0; i < 18; i++) send_pkt(3, 4, i);
    read_exp(3, 0, 18, "sat_rx");
    send_pkt(5, 4, 0);
    send_pkt(5, 4, 15);
    send_pkt(5, 4, 30);
    read_exp(5, 1, 28, "sat_lost");
    for (int i = 0; i < 17; i++) send_pkt(0, 2, 0);
    read_exp(0, 3, 17, "sat_mis");

    // clear and valid_in in the same cycle: clear wins
    valid_in = 1'b1; clear = 1'b1; node_start_in = 4'd0; node_dest_in = 4'd4;
    packet_id_in = 5'd3;
    @(posedge clk); #1;
    valid_in = 1'b0; clear = 1'b0;
    model_clear();
    check_err("clr_valid");
    read_exp(0, 0, 0, "clr_valid_rx");
    read_exp(3, 0, 0, "clr_valid_rx3");
    read_exp(0, 3, 0, "clr_valid_mis");

    // reset in the middle of a response
    send_pkt(0, 1, 0);
    rd_req = 1'b1; rd_src = 4'd0; rd_sel = 2'd3;
    @(posedge clk); #1;
    rd_req = 1'b0;
    check("rst_mid_ack", 32'(rd_ack), 32'd1);
    check("rst_mid_data", 32'(rd_data), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ack_drop", 32'(rd_ack), 32'd0);
    check("rst_mid_data_zero", 32'(rd_data), 32'd0);
    check("rst_mid_sat_ack", 32'(sat_rd_ack), 32'd0);
    rst_n = 1'b1;
    model_clear();
    check_err("rst_mid");
    read_check(0, 3, "rst_mid_mis");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
